// File: rtl/regbank_write_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the
// register-bank write arbiter and related bank logic.
package regbank_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

  function automatic logic [NUM_REGS-1:0] idx2onehot(
    input logic [ADDR_W-1:0] idx
  );
    logic [NUM_REGS-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/regbank_write_arbiter_if.sv
// Producer-side write request bundle: packed valid/lock/addr/data
// from every requester and the one-hot ready back.
interface regbank_write_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import regbank_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_lock,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_lock,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regbank_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or
// after ptr, wrapping; one-hot grant plus its index.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic         found;
  logic [W:0]   sum;
  logic [W-1:0] j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (W+1)'(k);
      if (sum >= (W+1)'(N)) begin
        sum = sum - (W+1)'(N);
      end
      j = sum[W-1:0];
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Write-port arbiter for the register bank: round-robin grant,
// locked bursts, registered one-hot select/data to the bank.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  regbank_write_arbiter_if.slave bus,
  input  logic                stall,
  output logic [NUM_REGS-1:0] wr_sel,
  output logic [DATA_W-1:0]   wr_data,
  output logic                wr_en,
  output logic [2:0]          owner,
  output logic                locked
);

  arb_state_t state, nxt_state;

  logic [PW-1:0]      rr_ptr, nxt_ptr;
  logic [PW-1:0]      owner_q, nxt_owner;
  logic [PW-1:0]      g;
  logic               xfer;
  logic [NUM_REQ-1:0] rdy;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i] = bus.req_addr[i*ADDR_W +: ADDR_W];
      data_a[i] = bus.req_data[i*DATA_W +: DATA_W];
    end
  end

  rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    nxt_state = state;
    nxt_ptr   = rr_ptr;
    nxt_owner = owner_q;
    g         = owner_q;
    xfer      = 1'b0;
    rdy       = '0;
    if (!stall) begin
      unique case (state)
        ST_IDLE: begin
          rdy = pick_gnt;
          if (|bus.req_valid) begin
            xfer      = 1'b1;
            g         = pick_idx;
            nxt_owner = pick_idx;
            nxt_ptr   = (pick_idx == PW'(NUM_REQ-1)) ?
                        '0 : pick_idx + PW'(1);
            if (bus.req_lock[pick_idx]) begin
              nxt_state = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          rdy[owner_q] = bus.req_valid[owner_q];
          if (bus.req_valid[owner_q]) begin
            xfer = 1'b1;
            g    = owner_q;
            // Only a beat with lock low ends the burst.
            if (!bus.req_lock[owner_q]) begin
              nxt_state = ST_IDLE;
              nxt_ptr   = (owner_q == PW'(NUM_REQ-1)) ?
                          '0 : owner_q + PW'(1);
            end
          end
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = rdy & {NUM_REQ{rst_n}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      owner_q <= '0;
    end else begin
      state   <= nxt_state;
      rr_ptr  <= nxt_ptr;
      owner_q <= nxt_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel  <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
    end else if (xfer) begin
      wr_sel  <= idx2onehot(addr_a[g]);
      wr_data <= data_a[g];
      wr_en   <= 1'b1;
    end else begin
      wr_sel  <= '0;
      wr_en   <= 1'b0;
    end
  end

  assign owner  = 3'(owner_q);
  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed table-driven bench for regbank_write_arbiter plus a
// hand-written reset-during-burst sequence.
module tb_regbank_write_arbiter;
  import regbank_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [15:0] wr_sel;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [2:0]  owner;
  logic        locked;

  regbank_write_arbiter_if #(.NUM_REQ(4)) bus ();

  regbank_write_arbiter #(.NUM_REQ(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .stall   (stall),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .owner   (owner),
    .locked  (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         stall;
    logic [3:0]   valid;
    logic [3:0]   lock;
    logic [15:0]  addr;
    logic [127:0] data;
    logic [3:0]   ready;
    logic         locked;
    logic [15:0]  sel;
    logic         en;
    logic [31:0]  wdata;
    logic [2:0]   own;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   passed;

  localparam logic [127:0] D =
    {32'hA3, 32'hA2, 32'hA1, 32'hA0};
  localparam logic [127:0] DS =
    {32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0};
  localparam logic [127:0] DC =
    {32'hA3, 32'hA2, 32'h22, 32'h11};
  localparam logic [15:0] AD = {4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [15:0] AS = {4'd4, 4'd3, 4'd15, 4'd1};
  localparam logic [15:0] AC = {4'd4, 4'd3, 4'd3, 4'd3};

  task automatic add(
    input logic r, input logic s,
    input logic [3:0] v, input logic [3:0] l,
    input logic [15:0] a, input logic [127:0] d,
    input logic [3:0] rd, input logic lk,
    input logic [15:0] sl, input logic e,
    input logic [31:0] wd, input logic [2:0] o
  );
    vec_t t;
    t.rst_n = r;  t.stall = s;
    t.valid = v;  t.lock = l;
    t.addr = a;   t.data = d;
    t.ready = rd; t.locked = lk;
    t.sel = sl;   t.en = e;
    t.wdata = wd; t.own = o;
    vq.push_back(t);
  endtask

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    total++;
    if (act !== exp) begin
      $display("FAIL %s [%0d]: got %h expected %h",
               nm, idx, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic drive(input vec_t t);
    rst_n         = t.rst_n;
    stall         = t.stall;
    bus.req_valid = t.valid;
    bus.req_lock  = t.lock;
    bus.req_addr  = t.addr;
    bus.req_data  = t.data;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;

    // reset held with all requesters valid
    add(0,0,4'hF,4'h0,AD,D, 4'h0,0, 16'h0000,0,32'h0,0);
    add(0,0,4'hF,4'h0,AD,D, 4'h0,0, 16'h0000,0,32'h0,0);
    // round robin 0,1,2,3,0
    add(1,0,4'hF,4'h0,AD,D, 4'h1,0, 16'h0002,1,32'hA0,0);
    add(1,0,4'hF,4'h0,AD,D, 4'h2,0, 16'h0004,1,32'hA1,1);
    add(1,0,4'hF,4'h0,AD,D, 4'h4,0, 16'h0008,1,32'hA2,2);
    add(1,0,4'hF,4'h0,AD,D, 4'h8,0, 16'h0010,1,32'hA3,3);
    add(1,0,4'hF,4'h0,AD,D, 4'h1,0, 16'h0002,1,32'hA0,0);
    // locked burst from req 2: r5, r6, bubble, r7
    add(1,0,4'h4,4'h4,{4'd4,4'd5,4'd2,4'd1},D,
        4'h4,0, 16'h0020,1,32'hA2,2);
    add(1,0,4'hF,4'h4,{4'd4,4'd6,4'd2,4'd1},D,
        4'h4,1, 16'h0040,1,32'hA2,2);
    add(1,0,4'hB,4'h0,AD,D, 4'h0,1, 16'h0000,0,32'hA2,2);
    add(1,0,4'hF,4'h0,{4'd4,4'd7,4'd2,4'd1},D,
        4'h4,1, 16'h0080,1,32'hA2,2);
    // next grant req 3; lock on req 1 ignored
    add(1,0,4'hF,4'h2,AD,D, 4'h8,0, 16'h0010,1,32'hA3,3);
    // two stall cycles, then req 1 to r15
    add(1,1,4'h2,4'h0,AS,DS, 4'h0,0, 16'h0000,0,32'hA3,3);
    add(1,1,4'h2,4'h0,AS,DS, 4'h0,0, 16'h0000,0,32'hA3,3);
    add(1,0,4'h2,4'h0,AS,DS, 4'h2,0, 16'h8000,1,32'hDEADBEEF,1);
    // same-register contention, req 0 then req 1
    add(1,0,4'h3,4'h0,AC,DC, 4'h1,0, 16'h0008,1,32'h11,0);
    add(1,0,4'h3,4'h0,AC,DC, 4'h2,0, 16'h0008,1,32'h22,1);
    add(1,0,4'h0,4'h0,AC,DC, 4'h0,0, 16'h0000,0,32'h22,1);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk("req_ready", i, 32'(bus.req_ready), 32'(vq[i].ready));
      chk("locked", i, 32'(locked), 32'(vq[i].locked));
      @(posedge clk);
      #1;
      chk("wr_sel", i, 32'(wr_sel), 32'(vq[i].sel));
      chk("wr_en", i, 32'(wr_en), 32'(vq[i].en));
      chk("wr_data", i, wr_data, vq[i].wdata);
      chk("owner", i, 32'(owner), 32'(vq[i].own));
    end

    // reset while LOCKED: rr_ptr is 2, req 2 locks onto r3
    @(negedge clk);
    bus.req_valid = 4'h4;
    bus.req_lock  = 4'h4;
    bus.req_addr  = AD;
    bus.req_data  = D;
    #1;
    chk("mid_ready", 100, 32'(bus.req_ready), 32'h4);
    @(posedge clk);
    #1;
    chk("mid_locked", 100, 32'(locked), 32'h1);
    chk("mid_wr_en", 100, 32'(wr_en), 32'h1);
    chk("mid_wr_sel", 100, 32'(wr_sel), 32'h0008);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_locked", 101, 32'(locked), 32'h0);
    chk("rst_wr_en", 101, 32'(wr_en), 32'h0);
    chk("rst_wr_sel", 101, 32'(wr_sel), 32'h0);
    chk("rst_ready", 101, 32'(bus.req_ready), 32'h0);
    chk("rst_owner", 101, 32'(owner), 32'h0);
    chk("rst_wr_data", 101, wr_data, 32'h0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_lock  = 4'h0;
    #1;
    chk("rel_ready", 102, 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("rel_wr_sel", 102, 32'(wr_sel), 32'h0002);
    chk("rel_owner", 102, 32'(owner), 32'h0);
    chk("rel_locked", 102, 32'(locked), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
